arc4_crack: RTL and testbench

Brute-force ARC4 key-search engine. Starting from a loaded 24-bit key, it runs ARC4 (S-box init, KSA, PRGA) for each candidate over a length-prefixed ciphertext held in an external synchronous ROM (`ct_mem`). A candidate passes when every decrypted byte is printable ASCII. Several instances run in parallel at the top level with interleaved start keys and strides, and coordinate through `found`/`resume`. Passing plaintext goes to an external result memory.

---
 rtl/arc4_pkg.sv | 35 +++
 rtl/arc4_smem.sv | 20 ++
 rtl/arc4_crack.sv | 232 +++++++++++++++++++++++
 tb/tb_arc4_crack.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared states, constants and helpers for the ARC4 brute-force key-search engine.
package arc4_pkg;
    localparam int S_AW    = 8;
    localparam int S_DEPTH = 256;

    localparam logic [7:0]  PRINT_LO = 8'h20;
    localparam logic [7:0]  PRINT_HI = 8'h7E;
    localparam logic [23:0] KEY_MAX  = 24'hFFFFFF;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_RI,
        ST_KSA_J,
        ST_KSA_RJ,
        ST_KSA_SJ,
        ST_KSA_WJ,
        ST_RL_WAIT,
        ST_RL_LEN,
        ST_PRGA_RI,
        ST_PRGA_J,
        ST_PRGA_RJ,
        ST_PRGA_SJ,
        ST_PRGA_WJ,
        ST_PRGA_RP,
        ST_PRGA_X,
        ST_CHECK,
        ST_PAUSE,
        ST_DONE
    } state_t;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction
endpackage

// File: rtl/arc4_smem.sv
// 256x8 single-port synchronous RAM holding the ARC4 S-box; one-cycle read latency.
module arc4_smem
    import arc4_pkg::*;
(
    input  logic            clk,
    input  logic [S_AW-1:0] i_addr,
    input  logic [7:0]      i_wrdata,
    input  logic            i_wren,
    output logic [7:0]      o_rddata
);
    logic [7:0] r_mem [S_DEPTH];
    logic [7:0] r_rddata;

    always_ff @(posedge clk) begin
        if (i_wren) r_mem[i_addr] <= i_wrdata;
        r_rddata <= r_mem[i_addr];
    end

    assign o_rddata = r_rddata;
endmodule

// File: rtl/arc4_crack.sv
// ARC4 key-search engine: per candidate runs S init, KSA and PRGA over ct_mem and
// accepts the key when every decrypted byte is printable ASCII.
module arc4_crack
    import arc4_pkg::*;
#(
    parameter int  KEY_W     = 24,
    parameter int  MSG_DEPTH = 256,
    localparam int ADDR_W    = $clog2(MSG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [KEY_W+3:0]  initKey,
    input  logic              found,
    input  logic              resume,
    input  logic              mem_en,
    input  logic [7:0]        ct_rddata,
    output logic [ADDR_W-1:0] ct_addr,
    output logic              rdy,
    output logic [KEY_W-1:0]  key,
    output logic              key_valid,
    output logic              checked,
    output logic [ADDR_W-1:0] final_addr,
    output logic [7:0]        final_wrdata,
    output logic              final_wren
);
    state_t            r_state;
    logic              r_rdy, r_key_valid, r_checked, r_final_wren, r_pass;
    logic [KEY_W-1:0]  r_key;
    logic [4:0]        r_stride;
    logic [ADDR_W-1:0] r_ct_addr, r_final_addr, r_n;
    logic [7:0]        r_final_wrdata, r_len;
    logic [7:0]        r_i, r_j, r_si, r_sj;
    logic [1:0]        r_kidx;

    logic [7:0]        w_s_addr, w_s_wd, w_s_rd, w_kbyte, w_plain;
    logic              w_s_we, w_abort, w_exhausted;
    logic [KEY_W:0]    w_key_next;

    arc4_smem u_smem (
        .clk      (clk),
        .i_addr   (w_s_addr),
        .i_wrdata (w_s_wd),
        .i_wren   (w_s_we),
        .o_rddata (w_s_rd)
    );

    assign w_plain     = w_s_rd ^ ct_rddata;
    assign w_key_next  = {1'b0, r_key} + {{(KEY_W-4){1'b0}}, r_stride};
    assign w_exhausted = w_key_next > {1'b0, KEY_MAX};
    // A candidate that has already passed keeps its result even if another instance reports found.
    assign w_abort     = found && (r_state != ST_IDLE) && (r_state != ST_DONE)
                         && !((r_state == ST_CHECK) && r_pass);

    always_comb begin
        case (r_kidx)
            2'd0:    w_kbyte = r_key[23:16];
            2'd1:    w_kbyte = r_key[15:8];
            default: w_kbyte = r_key[7:0];
        endcase
    end

    always_comb begin
        w_s_addr = r_i;
        w_s_wd   = r_si;
        w_s_we   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_s_wd = r_i;
                w_s_we = 1'b1;
            end
            ST_KSA_RJ, ST_PRGA_RJ: w_s_addr = r_j;
            ST_KSA_SJ, ST_PRGA_SJ: begin
                w_s_wd = w_s_rd;
                w_s_we = 1'b1;
            end
            ST_KSA_WJ, ST_PRGA_WJ: begin
                w_s_addr = r_j;
                w_s_we   = 1'b1;
            end
            ST_PRGA_RI: w_s_addr = r_i + 8'd1;
            ST_PRGA_RP: w_s_addr = r_si + r_sj;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_rdy          <= 1'b1;
            r_key          <= '0;
            r_key_valid    <= 1'b0;
            r_checked      <= 1'b0;
            r_final_wren   <= 1'b0;
            r_final_addr   <= '0;
            r_final_wrdata <= '0;
            r_ct_addr      <= '0;
        end else begin
            r_checked    <= 1'b0;
            r_final_wren <= 1'b0;
            if (w_abort) begin
                r_state     <= ST_DONE;
                r_rdy       <= 1'b1;
                r_key_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (en) begin
                            r_key       <= initKey[KEY_W-1:0];
                            r_stride    <= {1'b0, initKey[KEY_W+3:KEY_W]} + 5'd1;
                            r_key_valid <= 1'b0;
                            r_rdy       <= 1'b0;
                            r_i         <= 8'd0;
                            r_state     <= ST_INIT;
                        end
                    end
                    ST_INIT: begin
                        r_i <= r_i + 8'd1;
                        if (r_i == 8'hFF) begin
                            r_j     <= 8'd0;
                            r_kidx  <= 2'd0;
                            r_state <= ST_KSA_RI;
                        end
                    end
                    ST_KSA_RI: r_state <= ST_KSA_J;
                    ST_KSA_J: begin
                        r_si    <= w_s_rd;
                        r_j     <= r_j + w_s_rd + w_kbyte;
                        r_state <= ST_KSA_RJ;
                    end
                    ST_KSA_RJ: r_state <= ST_KSA_SJ;
                    ST_KSA_SJ: r_state <= ST_KSA_WJ;
                    ST_KSA_WJ: begin
                        r_i    <= r_i + 8'd1;
                        r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
                        if (r_i == 8'hFF) begin
                            r_ct_addr <= '0;
                            r_state   <= ST_RL_WAIT;
                        end else begin
                            r_state <= ST_KSA_RI;
                        end
                    end
                    ST_RL_WAIT: r_state <= ST_RL_LEN;
                    ST_RL_LEN: begin
                        r_len <= ct_rddata;
                        r_i   <= 8'd0;
                        r_j   <= 8'd0;
                        r_n   <= 'd1;
                        if (mem_en) begin
                            r_final_wren   <= 1'b1;
                            r_final_addr   <= '0;
                            r_final_wrdata <= ct_rddata;
                        end
                        if (ct_rddata == 8'd0) begin
                            r_pass    <= 1'b1;
                            r_checked <= 1'b1;
                            r_state   <= ST_CHECK;
                        end else begin
                            r_state <= ST_PRGA_RI;
                        end
                    end
                    ST_PRGA_RI: begin
                        r_i       <= r_i + 8'd1;
                        r_ct_addr <= r_n;
                        r_state   <= ST_PRGA_J;
                    end
                    ST_PRGA_J: begin
                        r_si    <= w_s_rd;
                        r_j     <= r_j + w_s_rd;
                        r_state <= ST_PRGA_RJ;
                    end
                    ST_PRGA_RJ: r_state <= ST_PRGA_SJ;
                    ST_PRGA_SJ: begin
                        r_sj    <= w_s_rd;
                        r_state <= ST_PRGA_WJ;
                    end
                    ST_PRGA_WJ: r_state <= ST_PRGA_RP;
                    ST_PRGA_RP: r_state <= ST_PRGA_X;
                    ST_PRGA_X: begin
                        if (!is_print(w_plain)) begin
                            r_pass    <= 1'b0;
                            r_checked <= 1'b1;
                            r_state   <= ST_CHECK;
                        end else begin
                            if (mem_en) begin
                                r_final_wren   <= 1'b1;
                                r_final_addr   <= r_n;
                                r_final_wrdata <= w_plain;
                            end
                            if (r_n == r_len) begin
                                r_pass    <= 1'b1;
                                r_checked <= 1'b1;
                                r_state   <= ST_CHECK;
                            end else begin
                                r_n     <= r_n + 'd1;
                                r_state <= ST_PRGA_RI;
                            end
                        end
                    end
                    ST_CHECK, ST_PAUSE: begin
                        if ((r_state == ST_CHECK) && r_pass) begin
                            r_key_valid <= 1'b1;
                            r_rdy       <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (resume) begin
                            if (w_exhausted) begin
                                r_rdy   <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_key   <= w_key_next[KEY_W-1:0];
                                r_i     <= 8'd0;
                                r_state <= ST_INIT;
                            end
                        end else begin
                            r_state <= ST_PAUSE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rdy          = r_rdy;
    assign key          = r_key;
    assign key_valid    = r_key_valid;
    assign checked      = r_checked;
    assign ct_addr      = r_ct_addr;
    assign final_addr   = r_final_addr;
    assign final_wrdata = r_final_wrdata;
    assign final_wren   = r_final_wren;
endmodule

// File: tb/tb_arc4_crack.sv
// Directed testbench for arc4_crack with a behavioural ct_mem and result-memory capture.
module tb_arc4_crack;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, found, resume, mem_en;
    logic [27:0] initKey;
    logic [7:0]  ct_rddata, ct_addr, final_addr, final_wrdata;
    logic        rdy, key_valid, checked, final_wren;
    logic [23:0] key;

    logic [7:0]  ct_rom  [256];
    logic [7:0]  res_mem [256];
    logic [7:0]  ks      [256];
    logic [23:0] chk_keys [$];
    int          checks = 0;
    int          errors = 0;
    int          n_wr;
    logic        rdy_after_en;
    logic        timed_out;

    localparam string MSG = "Hello, ARC4 crack!";

    arc4_crack dut (
        .clk(clk), .rst_n(rst_n), .en(en), .initKey(initKey), .found(found),
        .resume(resume), .mem_en(mem_en), .ct_rddata(ct_rddata), .ct_addr(ct_addr),
        .rdy(rdy), .key(key), .key_valid(key_valid), .checked(checked),
        .final_addr(final_addr), .final_wrdata(final_wrdata), .final_wren(final_wren)
    );

    always @(posedge clk) ct_rddata <= ct_rom[ct_addr];

    task automatic gen_ks(input logic [23:0] k, input int len);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t, x;
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) s[n] = n[7:0];
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 8'd0; j = 8'd0;
        for (int n = 1; n <= len; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            x = s[i] + s[j];
            ks[n] = s[x];
        end
    endtask

    task automatic load_msg(input logic [23:0] k, input string m);
        gen_ks(k, m.len());
        for (int n = 0; n < 256; n++) ct_rom[n] = 8'h00;
        ct_rom[0] = m.len();
        for (int n = 1; n <= m.len(); n++) ct_rom[n] = m[n-1] ^ ks[n];
    endtask

    task automatic run_search(input logic [27:0] ik, input int budget);
        chk_keys.delete();
        n_wr = 0;
        timed_out = 1'b1;
        for (int n = 0; n < 256; n++) res_mem[n] = 8'h00;
        @(negedge clk);
        initKey = ik; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        rdy_after_en = rdy;
        for (int c = 0; c < budget; c++) begin
            if (checked) chk_keys.push_back(key);
            if (final_wren) begin res_mem[final_addr] = final_wrdata; n_wr++; end
            if (rdy) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
        if (timed_out) begin errors++; $display("FAIL run_timeout: rdy=%b want 1", rdy); end
        checks++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; found = 1'b0; resume = 1'b1; mem_en = 1'b1; initKey = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end checks++;
        if (key !== 24'h0) begin errors++; $display("FAIL reset_key: got %h want 000000", key); end checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b want 0", key_valid); end checks++;
        if (checked !== 1'b0) begin errors++; $display("FAIL reset_checked: got %b want 0", checked); end checks++;
        if (final_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", final_wren); end checks++;
        if (final_addr !== 8'h0) begin errors++; $display("FAIL reset_faddr: got %h want 00", final_addr); end checks++;
        if (final_wrdata !== 8'h0) begin errors++; $display("FAIL reset_fdata: got %h want 00", final_wrdata); end checks++;
        if (ct_addr !== 8'h0) begin errors++; $display("FAIL reset_ctaddr: got %h want 00", ct_addr); end checks++;
    endtask

    // Published ARC4 vector: key "Key", plaintext "Plaintext".
    task automatic test_known_vector;
        logic [7:0] ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        string exp = "Plaintext";
        for (int n = 0; n < 256; n++) ct_rom[n] = 8'h00;
        ct_rom[0] = 8'd9;
        for (int n = 0; n < 9; n++) ct_rom[n+1] = ct[n];
        mem_en = 1'b1; resume = 1'b1;
        run_search({4'h0, 24'h4B6579}, 3000);
        if (rdy_after_en !== 1'b0) begin errors++; $display("FAIL vec_rdy_drop: got %b want 0", rdy_after_en); end checks++;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL vec_kv: got %b want 1", key_valid); end checks++;
        if (key !== 24'h4B6579) begin errors++; $display("FAIL vec_key: got %h want 4b6579", key); end checks++;
        if (chk_keys.size() != 1) begin errors++; $display("FAIL vec_nchecked: got %0d want 1", chk_keys.size()); end checks++;
        if (n_wr != 10) begin errors++; $display("FAIL vec_nwr: got %0d want 10", n_wr); end checks++;
        if (res_mem[0] !== 8'd9) begin errors++; $display("FAIL vec_len: got %h want 09", res_mem[0]); end checks++;
        for (int n = 1; n <= 9; n++) begin
            if (res_mem[n] !== exp[n-1]) begin errors++; $display("FAIL vec_pt[%0d]: got %h want %h", n, res_mem[n], exp[n-1]); end
            checks++;
        end
    endtask

    task automatic test_known_key;
        load_msg(24'h000018, MSG);
        mem_en = 1'b1; resume = 1'b1;
        run_search({4'h0, 24'h000018}, 3000);
        if (key_valid !== 1'b1) begin errors++; $display("FAIL known_kv: got %b want 1", key_valid); end checks++;
        if (key !== 24'h000018) begin errors++; $display("FAIL known_key: got %h want 000018", key); end checks++;
        if (chk_keys.size() != 1) begin errors++; $display("FAIL known_nchecked: got %0d want 1", chk_keys.size()); end checks++;
        if (n_wr != MSG.len() + 1) begin errors++; $display("FAIL known_nwr: got %0d want %0d", n_wr, MSG.len() + 1); end checks++;
        if (res_mem[0] !== 8'(MSG.len())) begin errors++; $display("FAIL known_len: got %h want %h", res_mem[0], MSG.len()); end checks++;
        for (int n = 1; n <= MSG.len(); n++) begin
            if (res_mem[n] !== MSG[n-1]) begin errors++; $display("FAIL known_pt[%0d]: got %h want %h", n, res_mem[n], MSG[n-1]); end
            checks++;
        end
        found = 1'b1;
        repeat (2) @(negedge clk);
        if (key_valid !== 1'b1) begin errors++; $display("FAIL found_after_pass_kv: got %b want 1", key_valid); end checks++;
        found = 1'b0;
    endtask

    task automatic test_search;
        logic [23:0] exp1 [3] = '{24'd22, 24'd23, 24'd24};
        logic [23:0] exp2 [2] = '{24'd22, 24'd24};
        load_msg(24'h000018, MSG);
        mem_en = 1'b1; resume = 1'b1;
        run_search({4'h0, 24'd22}, 8000);
        if (chk_keys.size() != 3) begin errors++; $display("FAIL s1_nchecked: got %0d want 3", chk_keys.size()); end checks++;
        for (int n = 0; n < 3 && n < chk_keys.size(); n++) begin
            if (chk_keys[n] !== exp1[n]) begin errors++; $display("FAIL s1_cand[%0d]: got %h want %h", n, chk_keys[n], exp1[n]); end
            checks++;
        end
        if (key_valid !== 1'b1 || key !== 24'd24) begin errors++; $display("FAIL s1_final: got kv=%b key=%h want kv=1 key=000018", key_valid, key); end checks++;
        run_search({4'h1, 24'd22}, 6000);
        if (chk_keys.size() != 2) begin errors++; $display("FAIL s2_nchecked: got %0d want 2", chk_keys.size()); end checks++;
        for (int n = 0; n < 2 && n < chk_keys.size(); n++) begin
            if (chk_keys[n] !== exp2[n]) begin errors++; $display("FAIL s2_cand[%0d]: got %h want %h", n, chk_keys[n], exp2[n]); end
            checks++;
        end
        if (key_valid !== 1'b1 || key !== 24'd24) begin errors++; $display("FAIL s2_final: got kv=%b key=%h want kv=1 key=000018", key_valid, key); end checks++;
    endtask

    task automatic test_pause;
        int saw;
        load_msg(24'h000018, MSG);
        mem_en = 1'b1; resume = 1'b0;
        @(negedge clk);
        initKey = {4'h2, 24'd22}; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        saw = 0;
        for (int c = 0; c < 3000 && saw == 0; c++) begin
            if (checked) saw = 1; else @(negedge clk);
        end
        if (saw != 1) begin errors++; $display("FAIL pause_checked: got %0d want 1", saw); end checks++;
        if (key !== 24'd22) begin errors++; $display("FAIL pause_key_at_check: got %h want 000016", key); end checks++;
        saw = 0;
        repeat (20) begin @(negedge clk); if (checked) saw++; end
        if (saw != 0 || key !== 24'd22 || rdy !== 1'b0) begin
            errors++; $display("FAIL pause_hold: got extra=%0d key=%h rdy=%b want 0/000016/0", saw, key, rdy);
        end
        checks++;
        resume = 1'b1;
        @(negedge clk);
        if (key !== 24'd25) begin errors++; $display("FAIL pause_resume_key: got %h want 000019", key); end checks++;
        found = 1'b1;
        @(negedge clk);
        found = 1'b0;
        if (rdy !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL pause_found: got rdy=%b kv=%b want 1/0", rdy, key_valid); end checks++;
    endtask

    task automatic test_abort;
        load_msg(24'h000018, MSG);
        mem_en = 1'b1; resume = 1'b1; n_wr = 0;
        @(negedge clk);
        initKey = {4'h0, 24'd21}; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (400) begin @(negedge clk); if (final_wren) n_wr++; end
        if (rdy !== 1'b0) begin errors++; $display("FAIL abort_busy: got rdy=%b want 0", rdy); end checks++;
        found = 1'b1;
        @(negedge clk);
        if (final_wren) n_wr++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL abort_rdy: got %b want 1", rdy); end checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL abort_kv: got %b want 0", key_valid); end checks++;
        found = 1'b0;
        repeat (3) begin @(negedge clk); if (final_wren) n_wr++; end
        if (n_wr != 0) begin errors++; $display("FAIL abort_wren: got %0d want 0", n_wr); end checks++;
    endtask

    task automatic test_nowrite_exhaust;
        load_msg(24'h000018, MSG);
        mem_en = 1'b0; resume = 1'b1;
        run_search({4'h0, 24'h000018}, 3000);
        if (n_wr != 0) begin errors++; $display("FAIL nowr_wren: got %0d want 0", n_wr); end checks++;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL nowr_kv: got %b want 1", key_valid); end checks++;
        mem_en = 1'b1;
        run_search({4'h0, 24'hFFFFFF}, 3000);
        if (chk_keys.size() != 1) begin errors++; $display("FAIL exh_nchecked: got %0d want 1", chk_keys.size()); end checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL exh_kv: got %b want 0", key_valid); end checks++;
        if (key !== 24'hFFFFFF) begin errors++; $display("FAIL exh_key: got %h want ffffff", key); end checks++;
    endtask

    task automatic test_len0_and_midreset;
        for (int n = 0; n < 256; n++) ct_rom[n] = 8'h00;
        mem_en = 1'b1; resume = 1'b1;
        run_search({4'h0, 24'h000005}, 3000);
        if (key_valid !== 1'b1) begin errors++; $display("FAIL len0_kv: got %b want 1", key_valid); end checks++;
        if (n_wr != 1 || res_mem[0] !== 8'h00) begin errors++; $display("FAIL len0_wr: got n=%0d d=%h want 1/00", n_wr, res_mem[0]); end checks++;
        @(negedge clk);
        initKey = {4'h0, 24'd22}; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if (rdy !== 1'b1 || key !== 24'h0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL midreset: got rdy=%b key=%h kv=%b want 1/000000/0", rdy, key, key_valid);
        end
        checks++;
    endtask

    initial begin
        test_reset;
        test_known_vector;
        test_known_key;
        test_search;
        test_pause;
        test_abort;
        test_nowrite_exhaust;
        test_len0_and_midreset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
